// File: rtl/stream_source_arbiter.sv
// rtl/stream_source_arbiter.sv - round-robin merger of FWFT source FIFOs into one framed FWFT stream
//
// Each grant emits one header word {4'hA, 1'b0, source[2:0], seq[7:0]} followed by
// 1..BURST_MAX data words popped from the granted source.
//
// Ports:
//   BUS_CLK     clock, rising edge
//   RST         synchronous active-high reset
//   SRC_ENABLE  per-source enable, looked at only when arbitrating
//   SRC_EMPTY   per-source FWFT empty flag
//   SRC_DATA    per-source head word, source i at [16*i+15:16*i]
//   SRC_READ    per-source pop strobe (combinational)
//   OUT_EMPTY   output FWFT empty flag
//   OUT_DATA    output head word
//   OUT_READ    output pop strobe, ignored while OUT_EMPTY=1
//   BUSY        high while a frame is in progress (header or data)
//   GRANT       currently or last granted source index
module stream_source_arbiter #(
    parameter int N_SRC     = 4,
    parameter int BURST_MAX = 16
) (
    input  logic                BUS_CLK,
    input  logic                RST,
    input  logic [N_SRC-1:0]    SRC_ENABLE,
    input  logic [N_SRC-1:0]    SRC_EMPTY,
    input  logic [16*N_SRC-1:0] SRC_DATA,
    output logic [N_SRC-1:0]    SRC_READ,
    output logic                OUT_EMPTY,
    output logic [15:0]         OUT_DATA,
    input  logic                OUT_READ,
    output logic                BUSY,
    output logic [2:0]          GRANT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam logic [2:0] LAST_SRC  = 3'(N_SRC - 1);
    localparam logic [7:0] LAST_WORD = 8'(BURST_MAX - 1);

    state_t           state, state_next;
    logic [2:0]       grant, grant_next;
    logic [7:0]       word_cnt, word_cnt_next;
    logic [7:0]       seq, seq_next;

    logic [N_SRC-1:0] req;
    logic             hi_found, lo_found;
    logic [2:0]       hi_idx, lo_idx, arb_idx;
    logic             cur_empty;
    logic [15:0]      cur_data;

    assign req = SRC_ENABLE & ~SRC_EMPTY;

    // Head of the granted source.
    always_comb begin
        cur_empty = 1'b1;
        cur_data  = 16'h0000;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant == 3'(i)) begin
                cur_empty = SRC_EMPTY[i];
                cur_data  = SRC_DATA[16*i +: 16];
            end
        end
    end

    // Round-robin pick: the lowest requester above the last grant wins; if there is
    // none, wrap around and take the lowest requester overall (which may be the
    // last grant itself).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = 3'd0;
        lo_found = 1'b0;
        lo_idx   = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i] && !hi_found && (3'(i) > grant)) begin
                hi_found = 1'b1;
                hi_idx   = 3'(i);
            end
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
            end
        end
        arb_idx = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state    <= IDLE;
            grant    <= LAST_SRC;
            word_cnt <= 8'd0;
            seq      <= 8'd0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            word_cnt <= word_cnt_next;
            seq      <= seq_next;
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        word_cnt_next = word_cnt;
        seq_next      = seq;
        OUT_EMPTY     = 1'b1;
        OUT_DATA      = 16'h0000;
        SRC_READ      = '0;

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_next = arb_idx;
                    state_next = HEADER;
                end
            end

            HEADER: begin
                OUT_EMPTY = 1'b0;
                OUT_DATA  = {4'hA, 1'b0, grant, seq};
                if (OUT_READ) begin
                    seq_next      = seq + 8'd1;
                    word_cnt_next = 8'd0;
                    state_next    = DATA;
                end
            end

            DATA: begin
                OUT_EMPTY = cur_empty;
                OUT_DATA  = cur_data;
                // A source that runs dry ends the burst rather than being waited for.
                if (cur_empty) begin
                    state_next = IDLE;
                end else if (OUT_READ) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        SRC_READ[i] = (grant == 3'(i));
                    end
                    word_cnt_next = word_cnt + 8'd1;
                    if (word_cnt == LAST_WORD) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset wins over the state decode so no word is popped from a source in the
        // cycle the frame is being torn down.
        if (RST) begin
            OUT_EMPTY = 1'b1;
            OUT_DATA  = 16'h0000;
            SRC_READ  = '0;
        end
    end

    assign BUSY  = !RST && (state != IDLE);
    assign GRANT = RST ? LAST_SRC : grant;

endmodule

// File: tb/tb_stream_source_arbiter.sv
// tb/tb_stream_source_arbiter.sv - self-checking bench for stream_source_arbiter
module tb_stream_source_arbiter;

    localparam int N  = 4;
    localparam int BM = 16;

    logic            BUS_CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    SRC_ENABLE;
    logic [N-1:0]    SRC_EMPTY;
    logic [16*N-1:0] SRC_DATA;
    logic [N-1:0]    SRC_READ;
    logic            OUT_EMPTY;
    logic [15:0]     OUT_DATA;
    logic            OUT_READ;
    logic            BUSY;
    logic [2:0]      GRANT;

    always #5 BUS_CLK = ~BUS_CLK;

    stream_source_arbiter #(.N_SRC(N), .BURST_MAX(BM)) dut (
        .BUS_CLK    (BUS_CLK),
        .RST        (RST),
        .SRC_ENABLE (SRC_ENABLE),
        .SRC_EMPTY  (SRC_EMPTY),
        .SRC_DATA   (SRC_DATA),
        .SRC_READ   (SRC_READ),
        .OUT_EMPTY  (OUT_EMPTY),
        .OUT_DATA   (OUT_DATA),
        .OUT_READ   (OUT_READ),
        .BUSY       (BUSY),
        .GRANT      (GRANT)
    );

    logic [15:0] srcq [N][$];
    logic [15:0] exp_q [$];
    logic [16:0] cyc_q [$];
    int tests = 0;
    int fails = 0;

    logic [N-1:0] s_rd;
    logic         s_empty, s_busy, s_oread;
    logic [15:0]  s_data;
    logic [2:0]   s_grant;

    typedef struct {
        int         prev;
        logic [3:0] en;
        logic [3:0] full;
        bit         none;
        logic [2:0] exp_g;
    } arb_vec_t;
    arb_vec_t vecs [8];

    function automatic logic [15:0] hdr(input int s, input int q);
        return {4'hA, 1'b0, 3'(s), 8'(q)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            SRC_EMPTY[i]         = (srcq[i].size() == 0);
            SRC_DATA[16*i +: 16] = (srcq[i].size() == 0) ? 16'h0000 : srcq[i][0];
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive_src();
    endtask

    // Sample outputs mid-cycle, then let the edge happen and retire popped words.
    task automatic tick();
        @(negedge BUS_CLK);
        s_rd    = SRC_READ;
        s_empty = OUT_EMPTY;
        s_data  = OUT_DATA;
        s_busy  = BUSY;
        s_grant = GRANT;
        s_oread = OUT_READ;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N; i++)
            if (s_rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive_src();
    endtask

    task automatic do_reset(input int cycles);
        RST      = 1'b1;
        OUT_READ = 1'b0;
        repeat (cycles) tick();
        RST = 1'b0;
    endtask

    task automatic start();
        clear_srcs();
        SRC_ENABLE = '1;
        do_reset(2);
    endtask

    task automatic cyc_push(input bit v, input logic [15:0] d);
        cyc_q.push_back({v, d});
    endtask

    task automatic expect_cycles(input string name);
        for (int k = 0; k < cyc_q.size(); k++) begin
            OUT_READ = 1'b1;
            tick();
            chk({name, " valid"}, {31'd0, !s_empty}, {31'd0, cyc_q[k][16]});
            if (cyc_q[k][16]) chk({name, " data"}, s_data, cyc_q[k][15:0]);
        end
        cyc_q.delete();
    endtask

    // Expected word stream from round-robin rules, given current contents and enables.
    task automatic build_expected(input int start_g, input int start_seq);
        int rem[N];
        int pos[N];
        int g, sq, s, n;
        bit found, more;
        exp_q.delete();
        g  = start_g;
        sq = start_seq;
        s  = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = SRC_ENABLE[i] ? srcq[i].size() : 0;
            pos[i] = 0;
        end
        more = 1'b1;
        while (more) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++)
                if (!found && rem[(g + k) % N] > 0) begin
                    found = 1'b1;
                    s     = (g + k) % N;
                end
            if (!found) begin
                more = 1'b0;
            end else begin
                g = s;
                exp_q.push_back(hdr(s, sq));
                sq = (sq + 1) % 256;
                n  = (rem[s] < BM) ? rem[s] : BM;
                for (int j = 0; j < n; j++) exp_q.push_back(srcq[s][pos[s] + j]);
                pos[s] += n;
                rem[s] -= n;
            end
        end
    endtask

    task automatic run_stream(input string name, input int rd_pct, input int budget,
                              input int dis_at, input int dis_src);
        int idx = 0;
        int cyc = 0;
        while (idx < exp_q.size() && cyc < budget) begin
            OUT_READ = ($urandom_range(99) < rd_pct);
            tick();
            cyc++;
            if (!s_oread) chk({name, " src_read_while_no_out_read"}, s_rd, 0);
            if (s_oread && !s_empty) begin
                chk({name, " word"}, s_data, exp_q[idx]);
                idx++;
                if (idx == dis_at) SRC_ENABLE = SRC_ENABLE & ~N'(1 << dis_src);
            end
        end
        chk({name, " words_seen"}, idx, exp_q.size());
        OUT_READ = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt[N];
        logic [N-1:0] en;

        vecs[0] = '{3, 4'hF, 4'hF, 1'b0, 3'd0};
        vecs[1] = '{0, 4'hF, 4'hF, 1'b0, 3'd1};
        vecs[2] = '{1, 4'hF, 4'b1001, 1'b0, 3'd3};
        vecs[3] = '{3, 4'b1100, 4'hF, 1'b0, 3'd2};
        vecs[4] = '{2, 4'hF, 4'b0100, 1'b0, 3'd2};
        vecs[5] = '{1, 4'b0011, 4'b0011, 1'b0, 3'd0};
        vecs[6] = '{0, 4'b1110, 4'b0001, 1'b1, 3'd0};
        vecs[7] = '{2, 4'hF, 4'b0011, 1'b0, 3'd0};

        RST = 1'b1;
        OUT_READ = 1'b0;
        SRC_ENABLE = '1;
        clear_srcs();

        // Reset with every source full and the consumer reading.
        for (int i = 0; i < N; i++) srcq[i].push_back(16'h5000 + 16'(i));
        drive_src();
        RST = 1'b1;
        OUT_READ = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset out_empty", s_empty, 1);
            chk("reset src_read", s_rd, 0);
            chk("reset busy", s_busy, 0);
            chk("reset grant", s_grant, N - 1);
            chk("reset out_data", s_data, 0);
        end
        RST = 1'b0;
        OUT_READ = 1'b0;
        tick();
        chk("first idle out_empty", s_empty, 1);
        tick();
        chk("first header valid", s_empty, 0);
        chk("first header data", s_data, 16'hA000);
        chk("first header busy", s_busy, 1);
        chk("first header grant", s_grant, 0);

        // Arbitration table: establish a last grant, then present a request pattern.
        for (int v = 0; v < 8; v++) begin
            clear_srcs();
            SRC_ENABLE = '0;
            do_reset(2);
            srcq[vecs[v].prev].push_back(16'hBEEF);
            SRC_ENABLE = N'(1 << vecs[v].prev);
            drive_src();
            OUT_READ = 1'b1;
            repeat (4) tick();
            OUT_READ = 1'b0;
            for (int i = 0; i < N; i++)
                if (vecs[v].full[i]) srcq[i].push_back(16'h1000 + 16'(i));
            SRC_ENABLE = vecs[v].en;
            drive_src();
            tick();
            chk("vec arb cycle empty", s_empty, 1);
            tick();
            if (vecs[v].none) begin
                chk("vec none empty", s_empty, 1);
                chk("vec none busy", s_busy, 0);
                chk("vec none grant", s_grant, vecs[v].prev);
            end else begin
                chk("vec header", s_data, hdr(vecs[v].exp_g, 1));
                chk("vec grant", s_grant, vecs[v].exp_g);
                chk("vec valid", s_empty, 0);
            end
        end

        // Short burst from source 2, then a second frame showing seq advanced.
        start();
        srcq[2] = '{16'h1111, 16'h2222, 16'h3333};
        drive_src();
        cyc_push(0, 0); cyc_push(1, 16'hA200);
        cyc_push(1, 16'h1111); cyc_push(1, 16'h2222); cyc_push(1, 16'h3333);
        cyc_push(0, 0); cyc_push(0, 0);
        expect_cycles("short burst");
        srcq[2].push_back(16'h4444);
        drive_src();
        cyc_push(0, 0); cyc_push(1, 16'hA201); cyc_push(1, 16'h4444);
        cyc_push(0, 0); cyc_push(0, 0);
        expect_cycles("short burst seq");

        // Burst limit: 40 words split 16/16/8 with a single idle cycle between frames.
        start();
        for (int k = 0; k < 40; k++) srcq[0].push_back(16'h0100 + 16'(k));
        drive_src();
        cyc_push(0, 0);
        for (int f = 0; f < 3; f++) begin
            cyc_push(1, hdr(0, f));
            for (int k = 0; k < ((f < 2) ? 16 : 8); k++) cyc_push(1, 16'h0100 + 16'(f * 16 + k));
            cyc_push(0, 0);
        end
        cyc_push(0, 0);
        expect_cycles("burst limit");

        // Round-robin with all sources requesting.
        start();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 20; k++) srcq[i].push_back(16'(i << 12) | 16'(k));
        drive_src();
        build_expected(N - 1, 0);
        run_stream("round robin", 100, 400, -1, 0);

        // Source 1 disabled during its own burst: frame completes, then it is skipped.
        start();
        for (int k = 0; k < 2; k++)  srcq[0].push_back(16'hA0A0 + 16'(k));
        for (int k = 0; k < 20; k++) srcq[1].push_back(16'hB000 + 16'(k));
        for (int k = 0; k < 2; k++)  srcq[2].push_back(16'hC0C0 + 16'(k));
        drive_src();
        exp_q.delete();
        exp_q.push_back(hdr(0, 0));
        for (int k = 0; k < 2; k++)  exp_q.push_back(16'hA0A0 + 16'(k));
        exp_q.push_back(hdr(1, 1));
        for (int k = 0; k < 16; k++) exp_q.push_back(16'hB000 + 16'(k));
        exp_q.push_back(hdr(2, 2));
        for (int k = 0; k < 2; k++)  exp_q.push_back(16'hC0C0 + 16'(k));
        run_stream("disable mid burst", 100, 200, 4, 1);
        OUT_READ = 1'b1;
        repeat (4) tick();
        chk("disabled source skipped empty", s_empty, 1);
        chk("disabled source skipped busy", s_busy, 0);
        chk("disabled source words left", srcq[1].size(), 4);

        // Random contents, enables and consumer stalls.
        for (int r = 0; r < 6; r++) begin
            start();
            en = N'($urandom_range(1, (1 << N) - 1));
            SRC_ENABLE = en;
            for (int i = 0; i < N; i++) begin
                cnt[i] = $urandom_range(0, 40);
                for (int k = 0; k < cnt[i]; k++) srcq[i].push_back(16'($urandom));
            end
            drive_src();
            build_expected(N - 1, 0);
            run_stream("random", 50, 5000, -1, 0);
            for (int i = 0; i < N; i++)
                chk("random words left", srcq[i].size(), en[i] ? 0 : cnt[i]);
        end

        // 257 frames so the sequence byte wraps FF -> 00.
        start();
        SRC_ENABLE = N'(1);
        for (int k = 0; k < 257 * BM; k++) srcq[0].push_back(16'(k));
        drive_src();
        build_expected(N - 1, 0);
        run_stream("seq wrap", 100, 6000, -1, 0);

        // Reset in the middle of a data burst.
        start();
        SRC_ENABLE = 4'b1000;
        for (int k = 0; k < 5; k++)  srcq[0].push_back(16'h0E00 + 16'(k));
        for (int k = 0; k < 10; k++) srcq[3].push_back(16'h3E00 + 16'(k));
        drive_src();
        OUT_READ = 1'b1;
        tick();
        tick();
        chk("midrst header", s_data, 16'hA300);
        tick();
        tick();
        chk("midrst data", s_data, 16'h3E01);
        RST = 1'b1;
        tick();
        chk("midrst src_read in reset", s_rd, 0);
        RST = 1'b0;
        SRC_ENABLE = '1;
        tick();
        chk("midrst src_read after", s_rd, 0);
        chk("midrst empty after", s_empty, 1);
        chk("midrst busy after", s_busy, 0);
        chk("midrst grant after", s_grant, N - 1);
        tick();
        chk("midrst next header", s_data, 16'hA000);
        chk("midrst words left", srcq[3].size(), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
